alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, handshaked, registered-output successor to the datapath's combinational 16-bit ALU. It adds the following over that ALU:
- configurable width;
- a 3-bit opcode with shifts and an optional iterative multiply;
- a carry flag;
- valid/ready flow control on both sides.

It sits between the register-file read stage and writeback. The controller no longer needs to hard-time ALU latency.

## Interface
- `WIDTH`, default 16: operand/result width. Must be a power of 2, at least 4.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width. Derived; do not override.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `in_valid`  in  1  operands/op presented.
- `in_ready`  out  1  block can accept.
- `Ain`  in  WIDTH  operand A.
- `Bin`  in  WIDTH  operand B; also the shift amount via `Bin[SHW-1:0]`.
- `ALUop`  in  3  operation code.
- `out_valid`  out  1  result/flags valid.
- `out_ready`  in  1  consumer takes the result.
- `out`  out  WIDTH  registered result.
- `Z`  out  4  registered flags: [3] carry, [2] zero, [1] negative, [0] signed overflow.

## Operation
Opcodes, with result and C/V rules (N = `out[WIDTH-1]`, Z flag = `out == 0` for every op):
- 000 ADD: `Ain + Bin`. C = carry-out. V = operands share a sign and the result sign differs.
- 001 SUB: `Ain - Bin`. C = no borrow (`Ain >= Bin` unsigned). V = operand signs differ and the result sign differs from `Ain`.
- 010 AND: `Ain & Bin`. C = 0, V = 0.
- 011 NOT: `~Bin`. C = 0, V = 0.
- 100 LSL: `Ain << sh`. C = last bit shifted out; C = 0 when sh = 0. V = 0.
- 101 LSR: logical right shift by sh. C and V as for LSL.
- 110 ASR: arithmetic right shift by sh. C and V as for LSL.
- 111 MUL: low WIDTH bits of the unsigned product. V = 1 if the upper WIDTH product bits are nonzero. C = 0.

State machine:
- IDLE: `in_ready = 1`.
  - Accept (`in_valid & in_ready`) of a single-cycle op → DONE, with result and flags registered.
  - Accept of MUL → BUSY, with operands latched and counter = 0.
- BUSY: `in_ready = 0`. Processes one multiplier bit per cycle. When the counter reaches WIDTH-1 → DONE.
- DONE: `out_valid = 1`. `out` and `Z` are held stable while `out_ready = 0`.
  - If `out_ready = 1` and there is no new accept → IDLE.
  - `in_ready = out_ready` in DONE, so a new accept in the same cycle as the drain goes straight to DONE (single-cycle op) or BUSY (MUL). This gives back-to-back operation.

Inputs are sampled only on accept. Changes to `Ain`/`Bin`/`ALUop` after accept have no effect.

## Timing
- Reset value of every output, applied asynchronously: `out = 0`, `Z = 0`, `out_valid = 0`, `in_ready = 1` (state IDLE, counter 0).
- Single-cycle ops: accept at edge k → `out_valid` high after edge k. Latency 1; throughput 1/cycle when `out_ready` is held high.
- MUL (macro defined): accept at edge k → BUSY on edges k+1 … k+WIDTH → `out_valid` high after edge k+WIDTH. Latency WIDTH.
- Reset asserted during BUSY or DONE: the operation is discarded, with no partial result or flags. The first edge after deassertion may accept.
- `out_ready` high while `out_valid` is low is ignored.

## Configuration
- `ALU_PIPE_MUL_EN` defined:
  - MUL is implemented as above;
  - the BUSY state and the sub-module are present.
- Macro undefined:
  - BUSY is not synthesised;
  - MUL is accepted as a single-cycle op with `out = 0` and `Z = 4'b0100`;
  - latency is 1.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_e` enum (ADD…MUL, 3 bits);
  - flag index constants `FLAG_C = 3`, `FLAG_Z = 2`, `FLAG_N = 1`, `FLAG_V = 0`;
  - state enum `alu_state_e` (IDLE, BUSY, DONE).
- Sub-module `alu_mul_iter`:
  - shift-add multiplier;
  - 2·WIDTH accumulator and bit counter;
  - start/done interface;
  - instantiated only under `ALU_PIPE_MUL_EN`.

## Test plan
All scenarios run with WIDTH = 16.
- ADD `0x7FFF + 0x0001`, `out_ready = 1` → `out = 0x8000`, `Z = 4'b0011`; `out_valid` exactly one cycle after accept.
- SUB `0x0005 - 0x0005` → `out = 0x0000`, `Z = 4'b1100`. SUB `0x8000 - 0x0001` → `out = 0x7FFF`, `Z = 4'b1001`.
- Shifts: ASR `0x8000` by 4 → `0xF800`, `Z = 4'b0010`. LSL `0x8001` by 1 → `0x0002`, `Z = 4'b1000`. LSR by 0 → `Ain` unchanged, C = 0.
- MUL `0x0100 * 0x0100`:
  - macro on → `out = 0x0000`, `Z = 4'b0101`, `out_valid` exactly 16 cycles after accept, `in_ready = 0` throughout BUSY;
  - macro off → `out = 0x0000`, `Z = 4'b0100` after 1 cycle.
- Backpressure: hold `out_ready = 0` for 3 cycles after an AND result. `out`/`Z` stay stable and `in_ready = 0`. Then raise `out_ready` with `in_valid` high: the next result is valid the following cycle with no bubble.
- Assert `reset` mid-BUSY (cycle 5 of a MUL) → `out_valid`, `out`, `Z` read 0 immediately. After deassertion, an ADD `0x0001 + 0x0001` yields `0x0002` normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the pipelined ALU: opcode and state enums,
// flag bit positions within the Z flag vector.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    NOT = 3'b011,
    LSL = 3'b100,
    LSR = 3'b101,
    ASR = 3'b110,
    MUL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per clock.
// 'product' already includes the bit being processed, so it is final while 'done' is high.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               running;

  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = running && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      acc     <= '0;
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result and C/Z/N/V flags.
// Define ALU_PIPE_MUL_EN to build the iterative multiplier; otherwise MUL yields zero in one cycle.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [2:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       Z
);

  localparam int MSB = WIDTH - 1;

  alu_state_e       state, state_nxt;
  alu_op_e          op;
  logic [SHW-1:0]   sh;
  logic             accept;
  logic             load_res;
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] res;
  logic             c, v;
  logic [3:0]       flags;

  assign op        = alu_op_e'(ALUop);
  assign sh        = Bin[SHW-1:0];
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // Single-cycle datapath; shifts use a one-bit extension to capture the last bit out as carry.
  always_comb begin
    ext = '0;
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      ADD: begin
        ext = {1'b0, Ain} + {1'b0, Bin};
        res = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = (Ain[MSB] == Bin[MSB]) && (res[MSB] != Ain[MSB]);
      end
      SUB: begin
        ext = {1'b0, Ain} - {1'b0, Bin};
        res = ext[WIDTH-1:0];
        c   = ~ext[WIDTH];
        v   = (Ain[MSB] != Bin[MSB]) && (res[MSB] != Ain[MSB]);
      end
      AND: res = Ain & Bin;
      NOT: res = ~Bin;
      LSL: begin
        ext = {1'b0, Ain} << sh;
        res = ext[WIDTH-1:0];
        c   = ext[WIDTH];
      end
      LSR: begin
        ext = {Ain, 1'b0} >> sh;
        res = ext[WIDTH:1];
        c   = ext[0];
      end
      ASR: begin
        ext = $signed({Ain, 1'b0}) >>> sh;
        res = ext[WIDTH:1];
        c   = ext[0];
      end
      default: res = '0;
    endcase
    flags         = '0;
    flags[FLAG_C] = c;
    flags[FLAG_Z] = (res == '0);
    flags[FLAG_N] = res[MSB];
    flags[FLAG_V] = v;
  end

`ifdef ALU_PIPE_MUL_EN
  logic               mul_start;
  logic               mul_done;
  logic               load_mul;
  logic [2*WIDTH-1:0] mul_product;
  logic [3:0]         mul_flags;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (Ain),
    .b       (Bin),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_Z] = (mul_product[WIDTH-1:0] == '0);
    mul_flags[FLAG_N] = mul_product[MSB];
    mul_flags[FLAG_V] = |mul_product[2*WIDTH-1:WIDTH];
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // DONE re-accepts during the drain cycle, giving back-to-back results without a bubble.
  always_comb begin
    state_nxt = state;
    load_res  = 1'b0;
`ifdef ALU_PIPE_MUL_EN
    mul_start = 1'b0;
    load_mul  = 1'b0;
`endif
    case (state)
      IDLE, DONE: begin
        if (accept) begin
`ifdef ALU_PIPE_MUL_EN
          if (op == MUL) begin
            state_nxt = BUSY;
            mul_start = 1'b1;
          end else begin
            state_nxt = DONE;
            load_res  = 1'b1;
          end
`else
          state_nxt = DONE;
          load_res  = 1'b1;
`endif
        end else if ((state == DONE) && out_ready) begin
          state_nxt = IDLE;
        end
      end
`ifdef ALU_PIPE_MUL_EN
      BUSY: begin
        if (mul_done) begin
          state_nxt = DONE;
          load_mul  = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= '0;
      Z   <= '0;
    end else if (load_res) begin
      out <= res;
      Z   <= flags;
`ifdef ALU_PIPE_MUL_EN
    end else if (load_mul) begin
      out <= mul_product[WIDTH-1:0];
      Z   <= mul_flags;
`endif
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH 16): vector table through a scoreboard,
// plus hand sequences for latency, backpressure and reset during an operation.
module tb_alu_pipe;
  import alu_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Ain;
  logic [15:0] Bin;
  logic [2:0]  ALUop;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic [3:0]  Z;

  typedef struct {
    string       name;
    alu_op_e     op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] eo;
    logic [3:0]  ez;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flags;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   vec_count   = 0;
  int   miscompares = 0;

  alu_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Ain       (Ain),
    .Bin       (Bin),
    .ALUop     (ALUop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .Z         (Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one op, wait for the handshake, and queue its expected result.
  task automatic applyStimulus(input alu_op_e op, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] eo, input logic [3:0] ez);
    bit got;
    exp_t e;
    got = 0;
    ALUop    = op;
    Ain      = a;
    Bin      = b;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        got     = 1;
        e.res   = eo;
        e.flags = ez;
        sb.push_back(e);
      end
    end
    if (!got) begin
      vec_count++;
      miscompares++;
      $display("[TB] FAIL accept_timeout: op %0d never accepted", op);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid === 1'b1) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      vec_count++;
      miscompares++;
      $display("[TB] FAIL drain_timeout: %0d results outstanding", sb.size());
    end
  endtask

  // Scoreboard: a result is consumed at the edge following a negedge where valid and ready are both high.
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        vec_count++;
        miscompares++;
        $display("[TB] FAIL unexpected_result: out %0h Z %0h with empty scoreboard", out, Z);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("sb_out", {16'h0, out}, {16'h0, e.res});
        checkOutput("sb_flags", {28'h0, Z}, {28'h0, e.flags});
      end
    end
  end

  initial begin
    bit stable;

    vecs.push_back('{"add_ovf",   ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011});
    vecs.push_back('{"sub_zero",  SUB, 16'h0005, 16'h0005, 16'h0000, 4'b1100});
    vecs.push_back('{"sub_ovf",   SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b1001});
    vecs.push_back('{"asr4",      ASR, 16'h8000, 16'h0004, 16'hF800, 4'b0010});
    vecs.push_back('{"lsl1",      LSL, 16'h8001, 16'h0001, 16'h0002, 4'b1000});
    vecs.push_back('{"lsr0",      LSR, 16'h1234, 16'h0000, 16'h1234, 4'b0000});
    vecs.push_back('{"and",       AND, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000});
    vecs.push_back('{"not0",      NOT, 16'h1234, 16'h0000, 16'hFFFF, 4'b0010});
    vecs.push_back('{"add_carry", ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1100});
    vecs.push_back('{"sub_borrow",SUB, 16'h0001, 16'h0002, 16'hFFFF, 4'b0010});
    vecs.push_back('{"lsr1",      LSR, 16'h8001, 16'h0001, 16'h4000, 4'b1000});
    vecs.push_back('{"asr15",     ASR, 16'h4000, 16'h000F, 16'h0000, 4'b1100});
    vecs.push_back('{"lsl15",     LSL, 16'h0001, 16'h000F, 16'h8000, 4'b0010});
    vecs.push_back('{"add_negov", ADD, 16'h8000, 16'h8000, 16'h0000, 4'b1101});
    vecs.push_back('{"not_ffff",  NOT, 16'h0000, 16'hFFFF, 16'h0000, 4'b0100});
    vecs.push_back('{"lsl_shmask",LSL, 16'h0003, 16'h0011, 16'h0006, 4'b0000});
    vecs.push_back('{"and_zero",  AND, 16'h00FF, 16'hFF00, 16'h0000, 4'b0100});
`ifdef ALU_PIPE_MUL_EN
    vecs.push_back('{"mul_256",   MUL, 16'h0100, 16'h0100, 16'h0000, 4'b0101});
    vecs.push_back('{"mul_3x5",   MUL, 16'h0003, 16'h0005, 16'h000F, 4'b0000});
    vecs.push_back('{"mul_max",   MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0001});
`else
    vecs.push_back('{"mul_256",   MUL, 16'h0100, 16'h0100, 16'h0000, 4'b0100});
    vecs.push_back('{"mul_3x5",   MUL, 16'h0003, 16'h0005, 16'h0000, 4'b0100});
`endif
    vecs.push_back('{"add_after", ADD, 16'h1111, 16'h2222, 16'h3333, 4'b0000});

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    Ain       = '0;
    Bin       = '0;
    ALUop     = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out", {16'h0, out}, 32'h0);
    checkOutput("rst_Z", {28'h0, Z}, 32'h0);
    checkOutput("rst_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("rst_in_ready", {31'h0, in_ready}, 32'h1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Latency 1 and a one-cycle valid pulse for a single-cycle op.
    applyStimulus(ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011);
    checkOutput("add_latency", {31'h0, out_valid}, 32'h1);
    @(posedge clk);
    #1;
    checkOutput("add_pulse_end", {31'h0, out_valid}, 32'h0);
    waitDrain();

    // Back-to-back vector table with the consumer always ready.
    foreach (vecs[i])
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eo, vecs[i].ez);
    waitDrain();

    // MUL latency and in_ready behaviour.
`ifdef ALU_PIPE_MUL_EN
    applyStimulus(MUL, 16'h0100, 16'h0100, 16'h0000, 4'b0101);
    stable = 1;
    for (int i = 0; i < 15; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) stable = 0;
      @(posedge clk);
      #1;
    end
    if (in_ready !== 1'b0 || out_valid !== 1'b0) stable = 0;
    checkOutput("mul_busy_hold", {31'h0, stable}, 32'h1);
    @(posedge clk);
    #1;
    checkOutput("mul_latency16", {31'h0, out_valid}, 32'h1);
`else
    applyStimulus(MUL, 16'h0100, 16'h0100, 16'h0000, 4'b0100);
    checkOutput("mul_latency1", {31'h0, out_valid}, 32'h1);
`endif
    waitDrain();

    // Backpressure: result held while stalled, then drain and accept in the same cycle.
    out_ready = 1'b0;
    applyStimulus(AND, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000);
    checkOutput("bp_valid", {31'h0, out_valid}, 32'h1);
    ALUop    = ADD;
    Ain      = 16'h0001;
    Bin      = 16'h0001;
    in_valid = 1'b1;
    stable   = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (out !== 16'h3030 || Z !== 4'b0000 || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 0;
    end
    checkOutput("bp_stable", {31'h0, stable}, 32'h1);
    out_ready = 1'b1;
    sb.push_back('{16'h0002, 4'b0000});
    #1;
    checkOutput("bp_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("bp_no_bubble_valid", {31'h0, out_valid}, 32'h1);
    checkOutput("bp_no_bubble_out", {16'h0, out}, 32'h0002);
    waitDrain();

    // Reset part-way through an operation discards it completely.
    out_ready = 1'b0;
    applyStimulus(MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0001);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("midrst_out", {16'h0, out}, 32'h0);
    checkOutput("midrst_Z", {28'h0, Z}, 32'h0);
    checkOutput("midrst_in_ready", {31'h0, in_ready}, 32'h1);
    sb.delete();
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(ADD, 16'h0001, 16'h0001, 16'h0002, 4'b0000);
    waitDrain();
    repeat (20) @(posedge clk);
    #1;
    checkOutput("no_ghost_result", {31'h0, out_valid}, 32'h0);
    checkOutput("sb_empty", sb.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
